lsu_mem_port: RTL

// - Executes the memory-stage commands produced by the instruction decoder (ram_we, ram_w_op, mem_ext_op, is_load) on a word-wide request/ack data bus.
// - Generates byte strobes and replicated write data for stores.
// - Aligns and sign/zero-extends load data.
// - Stalls the pipeline for the full bus transaction. Sits between the EX/MEM pipeline register and data RAM.

---
 rtl/lsu_mem_port_pkg.sv | 41 ++++
 rtl/lsu_mem_port_if.sv | 20 ++
 rtl/lsu_load_align.sv | 22 ++
 rtl/lsu_mem_port.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - LSU command encodings, FSM states and alignment helper
package lsu_mem_port_pkg;

  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;

  localparam logic [2:0] MEM_EXT_B  = 3'd0;
  localparam logic [2:0] MEM_EXT_BU = 3'd1;
  localparam logic [2:0] MEM_EXT_H  = 3'd2;
  localparam logic [2:0] MEM_EXT_HU = 3'd3;
  localparam logic [2:0] MEM_EXT_W  = 3'd4;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Stores are sized by w_op, loads by ext_op; unknown codes are treated as words.
  function automatic logic is_aligned(input logic we, input logic [1:0] w_op,
                                      input logic [2:0] ext_op, input logic [1:0] a);
    logic [1:0] must_be_zero;
    must_be_zero = 2'b11;
    if (we) begin
      case (w_op)
        W_B:     must_be_zero = 2'b00;
        W_H:     must_be_zero = 2'b01;
        default: must_be_zero = 2'b11;
      endcase
    end else begin
      case (ext_op)
        MEM_EXT_B, MEM_EXT_BU: must_be_zero = 2'b00;
        MEM_EXT_H, MEM_EXT_HU: must_be_zero = 2'b01;
        default:               must_be_zero = 2'b11;
      endcase
    end
    return (a & must_be_zero) == 2'b00;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - word-wide request/ack data bus between LSU and data RAM
interface lsu_mem_port_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shift a read word to its byte lane and sign/zero-extend
module lsu_load_align
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ext_op,
  output logic [31:0] data
);
  logic [31:0] w;

  always_comb begin
    w = rdata >> {addr_lo, 3'b000};
    case (ext_op)
      MEM_EXT_B:  data = {{24{w[7]}}, w[7:0]};
      MEM_EXT_BU: data = {24'd0, w[7:0]};
      MEM_EXT_H:  data = {{16{w[15]}}, w[15:0]};
      MEM_EXT_HU: data = {16'd0, w[15:0]};
      default:    data = w;
    endcase
  end
endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - memory-stage load/store port: FSM, strobes, timeout, pipeline stall
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic          req_is_load,
  input  logic [1:0]    req_w_op,
  input  logic [2:0]    req_ext_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          misalign,
  output logic          bus_err,
  lsu_mem_port_if.master bus
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d, load_q, load_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]  ext_q, ext_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        cmd, aligned, accept, in_bus, in_done;
  logic [3:0]  strb;
  logic [31:0] wd, load_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ext_q   <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      load_q  <= load_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ext_q   <= ext_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cmd      = req_valid & (req_we | req_is_load);
    aligned  = is_aligned(req_we, req_w_op, req_ext_op, req_addr[1:0]);
    accept   = (state_q == LSU_IDLE) & cmd & aligned;
    misalign = (state_q == LSU_IDLE) & cmd & ~aligned;

    case (req_w_op)
      W_B: begin
        strb = 4'b0001 << req_addr[1:0];
        wd   = {4{req_wdata[7:0]}};
      end
      W_H: begin
        strb = req_addr[1] ? 4'b1100 : 4'b0011;
        wd   = {2{req_wdata[15:0]}};
      end
      default: begin
        strb = 4'b1111;
        wd   = req_wdata;
      end
    endcase

    state_d = state_q;
    we_d    = we_q;
    load_d  = load_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ext_d   = ext_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          state_d = LSU_BUS;
          we_d    = req_we;
          load_d  = req_is_load & ~req_we;   // a store wins when both are set
          addr_d  = req_addr;
          ext_d   = req_ext_op;
          wstrb_d = req_we ? strb : 4'b0000;
          wdata_d = wd;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      LSU_BUS: begin
        if (bus.bus_ack) begin
          state_d = LSU_DONE;
          rdata_d = bus.bus_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES))) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata   (rdata_q),
    .addr_lo (addr_q[1:0]),
    .ext_op  (ext_q),
    .data    (load_data)
  );

  assign in_bus        = (state_q == LSU_BUS);
  assign in_done       = (state_q == LSU_DONE);
  assign stall         = accept | in_bus;
  assign resp_valid    = in_done & load_q;
  assign bus_err       = in_done & err_q;
  assign resp_rdata    = in_done ? load_data : 32'd0;
  assign bus.bus_req   = in_bus;
  assign bus.bus_we    = in_bus & we_q;
  assign bus.bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.bus_wstrb = in_bus ? wstrb_q : 4'b0000;
  assign bus.bus_wdata = in_bus ? wdata_q : 32'd0;
endmodule
